// File: rtl/tiny_dnn_pkg.sv
// Shared types and defaults for the tiny_dnn output path: beat widths,
// the {last, data} FIFO entry and the TSTRB all-ones constant.
package tiny_dnn_pkg;

  localparam int PKG_DW = 32;
  localparam int PKG_LW = 12;

  typedef struct packed {
    logic              last;
    logic [PKG_DW-1:0] data;
  } fifo_entry_t;

  localparam logic [PKG_DW/8-1:0] TSTRB_ONES = '1;

endpackage

// File: rtl/axis_out_framer_out_fifo.sv
// Synchronous DEPTH-entry FIFO with registered storage and extra-bit
// pointers; flush clears both pointers so queued entries are dropped.
module out_fifo
  import tiny_dnn_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fifo_entry_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  T     din,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  T            mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; the framer masks the head while empty.
  always_ff @(posedge clk) begin
    if (push && !full && !flush)
      mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

endmodule

// File: rtl/axis_out_framer.sv
// Result-beat FIFO and TLAST framer driving the M_AXIS master port.
// Optional macro OUT_FRAME_CNT_EN enables the saturating frame_cnt counter.
module axis_out_framer
  import tiny_dnn_pkg::*;
#(
  parameter int DW    = PKG_DW,
  parameter int DEPTH = 4,
  parameter int LW    = PKG_LW
) (
  input  logic          AXIS_ACLK,
  input  logic          AXIS_ARESETN,
  input  logic          run,
  input  logic [LW-1:0] frame_len,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          M_AXIS_TVALID,
  output logic [DW-1:0] M_AXIS_TDATA,
  output logic [DW/8-1:0] M_AXIS_TSTRB,
  output logic          M_AXIS_TLAST,
  input  logic          M_AXIS_TREADY,
  output logic          frame_done,
  output logic [15:0]   frame_cnt
);

  logic          run_q;
  logic          run_rise;
  logic [LW-1:0] len_q;
  logic [LW-1:0] in_cnt;
  logic          beat_last;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          hs_last_p1;
  fifo_entry_t   wr_entry;
  fifo_entry_t   head;

  assign run_rise = run & ~run_q;

  // Accepting only once run_q is set keeps the rise cycle closed, so the
  // first beat of a run always sees the freshly latched frame length.
  assign in_ready  = run & run_q & ~full;
  assign push      = in_valid & in_ready;
  assign pop       = ~empty & M_AXIS_TREADY;
  assign beat_last = (len_q != '0) && (in_cnt == len_q - 1'b1);

  assign wr_entry.last = beat_last;
  assign wr_entry.data = in_data;

  // Input stage: frame position tracking
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      run_q  <= 1'b0;
      len_q  <= '0;
      in_cnt <= '0;
    end else begin
      run_q <= run;
      if (run_rise) begin
        len_q  <= frame_len;
        in_cnt <= '0;
      end else if (push) begin
        in_cnt <= beat_last ? '0 : in_cnt + 1'b1;
      end
    end
  end

  out_fifo #(
    .DEPTH (DEPTH),
    .T     (fifo_entry_t)
  ) u_fifo (
    .clk   (AXIS_ACLK),
    .rst_n (AXIS_ARESETN),
    .flush (~run),
    .push  (push),
    .pop   (pop),
    .din   (wr_entry),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Output stage: head of queue, masked while empty
  assign M_AXIS_TVALID = ~empty;
  assign M_AXIS_TDATA  = empty ? '0 : head.data;
  assign M_AXIS_TLAST  = ~empty & head.last;
  assign M_AXIS_TSTRB  = empty ? '0 : TSTRB_ONES;

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN)
      hs_last_p1 <= 1'b0;
    else
      hs_last_p1 <= pop & head.last;
  end

  assign frame_done = hs_last_p1;

`ifdef OUT_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN)
      frame_cnt_q <= '0;
    else if (run_rise)
      frame_cnt_q <= '0;
    else if (hs_last_p1 && (frame_cnt_q != 16'hFFFF))
      frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_axis_out_framer.sv
// Directed bench for axis_out_framer: framing, back-pressure, no-TLAST mode,
// flush and asynchronous reset; frame_cnt expectations follow OUT_FRAME_CNT_EN.
module tb_axis_out_framer;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [11:0] frame_len;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        tvalid;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tlast;
  logic        tready;
  logic        frame_done;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] hs_data [$];
  logic        hs_last [$];
  int          done_cnt = 0;

`ifdef OUT_FRAME_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  axis_out_framer dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESETN  (rst_n),
    .run           (run),
    .frame_len     (frame_len),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .M_AXIS_TVALID (tvalid),
    .M_AXIS_TDATA  (tdata),
    .M_AXIS_TSTRB  (tstrb),
    .M_AXIS_TLAST  (tlast),
    .M_AXIS_TREADY (tready),
    .frame_done    (frame_done),
    .frame_cnt     (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every output handshake (which completes at the next rising edge)
  always @(negedge clk) begin
    if (rst_n && tvalid && tready) begin
      hs_data.push_back(tdata);
      hs_last.push_back(tlast);
    end
    if (frame_done)
      done_cnt++;
  end

  task automatic start_run(input logic [11:0] len);
    run = 1'b0;
    @(posedge clk); #1;
    frame_len = len;
    run = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] d);
    bit acc;
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) done = 1'b1;
    end
    in_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout data=%h not accepted within 50 cycles", d);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; run = 1'b0; frame_len = '0; in_valid = 1'b0; in_data = '0; tready = 1'b0;
    #1;
    checks++;
    if ({in_ready, tvalid, tlast, frame_done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000", {in_ready, tvalid, tlast, frame_done});
    end
    checks++;
    if (tdata !== 32'h0 || tstrb !== 4'h0) begin
      errors++;
      $display("FAIL reset_data tdata=%h tstrb=%h want 0/0", tdata, tstrb);
    end
    checks++;
    if (frame_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_frame_cnt got %h want 0", frame_cnt);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_frame;
    int base, d0;
    logic [5:0] lasts;
    base = hs_data.size(); d0 = done_cnt;
    tready = 1'b1;
    start_run(12'd3);
    for (int i = 1; i <= 6; i++) send(32'(i));
    repeat (5) @(posedge clk); #1;
    checks++;
    if (hs_data.size() - base !== 6) begin
      errors++;
      $display("FAIL basic_count got %0d want 6", hs_data.size() - base);
    end else begin
      lasts = '0;
      for (int i = 0; i < 6; i++) begin
        lasts[i] = hs_last[base+i];
        checks++;
        if (hs_data[base+i] !== 32'(i+1)) begin
          errors++;
          $display("FAIL basic_data[%0d] got %h want %h", i, hs_data[base+i], i+1);
        end
      end
      checks++;
      if (lasts !== 6'b100100) begin
        errors++;
        $display("FAIL basic_tlast got %b want 100100", lasts);
      end
    end
    checks++;
    if (done_cnt - d0 !== 2) begin
      errors++;
      $display("FAIL basic_frame_done got %0d want 2", done_cnt - d0);
    end
    checks++;
    if (frame_cnt !== (CNT_ON ? 16'd2 : 16'd0)) begin
      errors++;
      $display("FAIL basic_frame_cnt got %0d want %0d", frame_cnt, CNT_ON ? 2 : 0);
    end
  endtask

  task automatic test_back_pressure;
    int base, acc_cnt;
    logic last_rdy;
    base = hs_data.size(); acc_cnt = 0; last_rdy = 1'b1;
    tready = 1'b0;
    start_run(12'd0);
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      @(negedge clk);
      last_rdy = in_ready;
      if (in_ready) acc_cnt++;
      @(posedge clk); #1;
    end
    checks++;
    if (acc_cnt !== 4 || last_rdy !== 1'b0) begin
      errors++;
      $display("FAIL bp_fill accepted=%0d ready5=%b want 4/0", acc_cnt, last_rdy);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (tvalid !== 1'b1 || tdata !== 32'h1 || tstrb !== 4'hF || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold tvalid=%b tdata=%h tstrb=%h in_ready=%b want 1/1/f/0",
                 tvalid, tdata, tstrb, in_ready);
      end
    end
    @(posedge clk); #1;
    tready = 1'b1;
    send(32'h5);
    repeat (6) @(posedge clk); #1;
    checks++;
    if (hs_data.size() - base !== 5) begin
      errors++;
      $display("FAIL bp_drain_count got %0d want 5", hs_data.size() - base);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (hs_data[base+i] !== 32'(i+1)) begin
          errors++;
          $display("FAIL bp_drain[%0d] got %h want %h", i, hs_data[base+i], i+1);
        end
      end
    end
  endtask

  task automatic test_no_tlast;
    int base, d0, nlast;
    base = hs_data.size(); d0 = done_cnt; nlast = 0;
    tready = 1'b1;
    start_run(12'd0);
    for (int i = 1; i <= 5000; i++) send(32'(i));
    repeat (4) @(posedge clk); #1;
    checks++;
    if (hs_data.size() - base !== 5000) begin
      errors++;
      $display("FAIL nolast_count got %0d want 5000", hs_data.size() - base);
    end else begin
      for (int i = 0; i < 5000; i++) if (hs_last[base+i] !== 1'b0) nlast++;
      checks++;
      if (nlast !== 0) begin
        errors++;
        $display("FAIL nolast_tlast got %0d beats with TLAST want 0", nlast);
      end
      checks++;
      if (hs_data[base+4096] !== 32'd4097 || hs_data[base+4999] !== 32'd5000) begin
        errors++;
        $display("FAIL nolast_data got %h/%h want 1001/1388",
                 hs_data[base+4096], hs_data[base+4999]);
      end
    end
    checks++;
    if (done_cnt - d0 !== 0) begin
      errors++;
      $display("FAIL nolast_frame_done got %0d want 0", done_cnt - d0);
    end
  endtask

  task automatic test_flush;
    int base, d0;
    tready = 1'b0;
    start_run(12'd2);
    for (int i = 1; i <= 3; i++) send(32'hF0 + 32'(i));
    run = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || tvalid !== 1'b1) begin
      errors++;
      $display("FAIL flush_same_cycle in_ready=%b tvalid=%b want 0/1", in_ready, tvalid);
    end
    @(negedge clk);
    checks++;
    if (tvalid !== 1'b0 || tdata !== 32'h0) begin
      errors++;
      $display("FAIL flush_next_cycle tvalid=%b tdata=%h want 0/0", tvalid, tdata);
    end
    @(posedge clk); #1;
    base = hs_data.size(); d0 = done_cnt;
    tready = 1'b1;
    start_run(12'd2);
    send(32'hA);
    send(32'hB);
    repeat (5) @(posedge clk); #1;
    checks++;
    if (hs_data.size() - base !== 2) begin
      errors++;
      $display("FAIL flush_restart_count got %0d want 2", hs_data.size() - base);
    end else begin
      checks++;
      if (hs_data[base] !== 32'hA || hs_data[base+1] !== 32'hB ||
          hs_last[base] !== 1'b0 || hs_last[base+1] !== 1'b1) begin
        errors++;
        $display("FAIL flush_restart got %h/%b %h/%b want a/0 b/1",
                 hs_data[base], hs_last[base], hs_data[base+1], hs_last[base+1]);
      end
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL flush_frame_done got %0d want 1", done_cnt - d0);
    end
  endtask

  task automatic test_async_reset;
    int base, d0;
    logic [3:0] lasts;
    tready = 1'b0;
    start_run(12'd4);
    send(32'h21);
    send(32'h22);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, tvalid, tlast, frame_done} !== 4'b0000 || tdata !== 32'h0 ||
        tstrb !== 4'h0 || frame_cnt !== 16'h0) begin
      errors++;
      $display("FAIL arst_outputs rdy=%b tv=%b tl=%b fd=%b td=%h ts=%h fc=%h want all 0",
               in_ready, tvalid, tlast, frame_done, tdata, tstrb, frame_cnt);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    base = hs_data.size(); d0 = done_cnt;
    tready = 1'b1;
    start_run(12'd4);
    for (int i = 1; i <= 4; i++) send(32'h30 + 32'(i));
    repeat (5) @(posedge clk); #1;
    checks++;
    if (hs_data.size() - base !== 4) begin
      errors++;
      $display("FAIL arst_restart_count got %0d want 4", hs_data.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) lasts[i] = hs_last[base+i];
      checks++;
      if (lasts !== 4'b1000 || hs_data[base+3] !== 32'h34) begin
        errors++;
        $display("FAIL arst_restart_tlast got %b last=%h want 1000 34", lasts, hs_data[base+3]);
      end
    end
    checks++;
    if (done_cnt - d0 !== 1 || frame_cnt !== (CNT_ON ? 16'd1 : 16'd0)) begin
      errors++;
      $display("FAIL arst_frame done=%0d cnt=%0d want 1/%0d", done_cnt - d0, frame_cnt,
               CNT_ON ? 1 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_back_pressure();
    test_no_tlast();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
